des3_seq_ctrl: RTL

//  Parametrised round sequencer and key store for the iterative (area) triple-DES core.

---
 rtl/des3_seq_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/des3_seq_ctrl.sv
// des3_seq_ctrl: round sequencer, key store and stream flow control for an iterative triple-DES core
module des3_seq_ctrl #(
    parameter int NUM_KEYSETS = 4,
    parameter int KEY_W       = 56,
    parameter int ROUNDS      = 48,
    parameter int RSEL_W      = 6,
    parameter int CORE_LAT    = 1,
    parameter int KS_W        = (NUM_KEYSETS > 1) ? $clog2(NUM_KEYSETS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [63:0]       in_data_i,
    input  logic              in_decrypt_i,
    input  logic [KS_W-1:0]   in_keysel_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [63:0]       out_data_o,
    input  logic              key_we_i,
    input  logic [KS_W-1:0]   key_addr_i,
    input  logic [1:0]        key_idx_i,
    input  logic [KEY_W-1:0]  key_data_i,
    output logic              key_err_o,
    output logic              busy_o,
    output logic [63:0]       core_desIn_o,
    output logic [KEY_W-1:0]  core_key1_o,
    output logic [KEY_W-1:0]  core_key2_o,
    output logic [KEY_W-1:0]  core_key3_o,
    output logic              core_decrypt_o,
    output logic [RSEL_W-1:0] core_roundSel_o,
    input  logic [63:0]       core_desOut_i
);
    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [RSEL_W-1:0] LAST = RSEL_W'(ROUNDS - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(CORE_LAT - 1);
    localparam logic [KS_W:0] NK = (KS_W + 1)'(NUM_KEYSETS);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [KS_W-1:0]   ks_q;
    logic [KEY_W-1:0]  tbl [2**KS_W][3];
    logic              accept, key_hit, key_rej, key_ok;

    assign in_ready_o = state_q == IDLE;
    assign busy_o     = !in_ready_o;
    assign accept     = in_valid_i && in_ready_o;
    // The block in flight owns its keyset; rewriting it mid-block would corrupt the result
    assign key_hit    = key_we_i && key_idx_i != 2'd3;
    assign key_rej    = key_hit && busy_o && key_addr_i == ks_q;
    assign key_ok     = key_hit && !key_rej && {1'b0, key_addr_i} < NK;

    assign core_key1_o = tbl[ks_q][0];
    assign core_key2_o = tbl[ks_q][1];
    assign core_key3_o = tbl[ks_q][2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid_i ? RUN : IDLE;
            RUN:     state_d = (core_roundSel_o == LAST) ? WAIT : RUN;
            WAIT:    state_d = (cnt_q == LAT_LAST) ? HOLD : WAIT;
            HOLD:    state_d = out_ready_i ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            core_desIn_o    <= '0;
            core_decrypt_o  <= 1'b0;
            ks_q            <= '0;
            core_roundSel_o <= '0;
            cnt_q           <= '0;
            out_data_o      <= '0;
            out_valid_o     <= 1'b0;
            key_err_o       <= 1'b0;
        end else begin
            if (accept) begin
                core_desIn_o   <= in_data_i;
                core_decrypt_o <= in_decrypt_i;
                ks_q           <= in_keysel_i;
            end
            core_roundSel_o <= (state_q == RUN && core_roundSel_o != LAST) ? core_roundSel_o + 1'b1 :
                               (state_q == HOLD && out_ready_i) ? '0 : core_roundSel_o;
            cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            if (state_q == WAIT && cnt_q == LAT_LAST) begin
                out_data_o  <= core_desOut_i;
                out_valid_o <= 1'b1;
            end else if (state_q == HOLD && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            key_err_o <= key_rej;
        end
    end

    // Entries at or beyond NUM_KEYSETS are never written, so they read as zero
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int a = 0; a < 2**KS_W; a++)
                for (int k = 0; k < 3; k++)
                    tbl[a][k] <= '0;
        end else if (key_ok) begin
            tbl[key_addr_i][key_idx_i] <= key_data_i;
        end
    end
endmodule
